// File: rtl/i2c_master_bit_ctrl_if.sv
// ----------------------------------------------------------------------------
// i2c_master_bit_ctrl_if
//
// Bundles the request handshake and the SCL/SDA bus signals of the I2C
// bit-level engine.
//
// Parameter:
//   DIV_WIDTH  width of the per-slot clock divider (must match the engine)
//
// Signals:
//   go        request strobe, sampled with command when idle or on finish
//   command   3-bit bit command (READ/START/STOP/DATA_0/DATA_1/ACK/NACK)
//   clk_div   slot length minus one, in clock cycles
//   scl_in    synchronised SCL bus level
//   sda_in    synchronised SDA bus level
//   scl       SCL drive (1 = release, 0 = pull low)
//   sda       SDA drive (1 = release, 0 = pull low)
//   busy      bit in progress
//   finish    one-cycle completion pulse
//   rx_bit    SDA level sampled during the last READ_BIT
//   arb_lost  one-cycle arbitration-loss pulse, coincident with finish
//
// Modports:
//   master  requester side (byte-level FSM plus pad synchronisers)
//   slave   the bit engine itself
// ----------------------------------------------------------------------------
interface i2c_master_bit_ctrl_if #(
  parameter int DIV_WIDTH = 16
);

  logic                 go;
  logic [2:0]           command;
  logic [DIV_WIDTH-1:0] clk_div;
  logic                 scl_in;
  logic                 sda_in;
  logic                 scl;
  logic                 sda;
  logic                 busy;
  logic                 finish;
  logic                 rx_bit;
  logic                 arb_lost;

  modport master (
    output go, command, clk_div, scl_in, sda_in,
    input  scl, sda, busy, finish, rx_bit, arb_lost
  );

  modport slave (
    input  go, command, clk_div, scl_in, sda_in,
    output scl, sda, busy, finish, rx_bit, arb_lost
  );

endinterface

// File: rtl/i2c_master_bit_ctrl.sv
// ----------------------------------------------------------------------------
// i2c_master_bit_ctrl
//
// I2C master bit-level engine. Each accepted request produces exactly one
// START, STOP, data, ACK/NACK or read bit on the open-drain SCL/SDA drives.
// A bit is split into 8 slots of (clk_div+1) clock cycles each; the SCL/SDA
// drive levels are a fixed pattern per command and slot. The engine samples
// the slave's SDA for READ_BIT, detects multi-master arbitration loss and can
// optionally honour slave clock stretching.
//
// Parameter:
//   DIV_WIDTH  width of the per-slot clock divider
//
// Ports:
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       i2c_master_bit_ctrl_if.slave (request handshake + bus signals)
//
// Optional feature (compile-time macro I2C_CLOCK_STRETCH_EN):
//   defined   - in slot 4 of every command except START the tick counter
//               holds at 0 while scl_in is low, so slot 4 lasts clk_div+1
//               cycles after SCL is first seen high (no timeout).
//   undefined - scl_in is ignored and timing is purely divider based.
// ----------------------------------------------------------------------------
module i2c_master_bit_ctrl #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  i2c_master_bit_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_READ  = 3'b001,
    CMD_START = 3'b010,
    CMD_STOP  = 3'b011,
    CMD_DATA0 = 3'b100,
    CMD_DATA1 = 3'b101,
    CMD_ACK   = 3'b110,
    CMD_NACK  = 3'b111
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [DIV_WIDTH-1:0] TICK_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  // Drive pattern {scl, sda} for a command in a given slot. Slot 0 of the
  // non-START commands keeps SDA where it was while SCL goes low, so a data
  // change never happens with SCL high.
  function automatic logic [1:0] slot_drive(input cmd_e cmd, input logic [2:0] slot,
                                            input logic sda_hold);
    logic scl_v;
    logic sda_v;
    scl_v = 1'b1;
    sda_v = sda_hold;
    case (cmd)
      CMD_START: begin
        scl_v = 1'b1;
        sda_v = (slot < 3'd6);
      end
      CMD_STOP: begin
        scl_v = (slot >= 3'd4);
        sda_v = (slot == 3'd0) ? sda_hold : (slot >= 3'd6);
      end
      CMD_DATA0, CMD_ACK: begin
        scl_v = (slot >= 3'd4);
        sda_v = (slot == 3'd0) ? sda_hold : 1'b0;
      end
      CMD_DATA1, CMD_NACK, CMD_READ: begin
        scl_v = (slot >= 3'd4);
        sda_v = (slot == 3'd0) ? sda_hold : 1'b1;
      end
      default: begin
        scl_v = 1'b1;
        sda_v = sda_hold;
      end
    endcase
    return {scl_v, sda_v};
  endfunction

  state_e               state_q,  state_d;
  cmd_e                 cmd_q,    cmd_d;
  logic [DIV_WIDTH-1:0] div_q,    div_d;
  logic [2:0]           slot_q,   slot_d;
  logic [DIV_WIDTH-1:0] tick_q,   tick_d;
  logic                 scl_q,    scl_d;
  logic                 sda_q,    sda_d;
  logic                 busy_q,   busy_d;
  logic                 rx_bit_q, rx_bit_d;

  logic go_valid_s;
  logic stretch_hold_s;
  logic slot_end_s;
  logic arb_loss_s;
  logic bit_end_s;
  logic accept_s;
  logic finish_s;
  logic arb_lost_s;

  assign go_valid_s = bus.go && (bus.command != 3'b000);

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low after we released it in slot 4 freezes the slot.
  assign stretch_hold_s = (state_q == ST_RUN) && (cmd_q != CMD_START) &&
                          (slot_q == 3'd4) && !bus.scl_in;
`else
  assign stretch_hold_s = 1'b0;
  logic unused_scl_in_s;
  assign unused_scl_in_s = bus.scl_in;
`endif

  // Final tick of the current slot; a stretched slot never ends.
  assign slot_end_s = (state_q == ST_RUN) && (tick_q == div_q) && !stretch_hold_s;

  // Another master won if we released SDA but the bus reads low. READ_BIT is
  // excluded because a low SDA there is the slave's data, not a competitor.
  assign arb_loss_s = slot_end_s && (cmd_q != CMD_READ) &&
                      ((slot_q == 3'd5) || (slot_q == 3'd7)) &&
                      sda_q && !bus.sda_in;

  assign bit_end_s = slot_end_s && (slot_q == 3'd7);

  // A new request is taken when idle or back-to-back on a normal completion;
  // go is deliberately ignored in an arbitration-loss cycle.
  assign accept_s = go_valid_s && ((state_q == ST_IDLE) || (bit_end_s && !arb_loss_s));

  // Next-state and next-output logic for the slot/tick sequencer.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    div_d      = div_q;
    slot_d     = slot_q;
    tick_d     = tick_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    rx_bit_d   = rx_bit_q;
    finish_s   = 1'b0;
    arb_lost_s = 1'b0;

    if ((state_q == ST_RUN) && slot_end_s && (cmd_q == CMD_READ) && (slot_q == 3'd5)) begin
      rx_bit_d = bus.sda_in;
    end else begin
      rx_bit_d = rx_bit_q;
    end

    if (accept_s) begin
      // Covers both the idle accept and the no-gap follow-on bit; the
      // finish pulse of the completing bit is still raised here.
      finish_s       = (state_q == ST_RUN);
      state_d        = ST_RUN;
      cmd_d          = cmd_e'(bus.command);
      div_d          = bus.clk_div;
      slot_d         = 3'd0;
      tick_d         = '0;
      {scl_d, sda_d} = slot_drive(cmd_e'(bus.command), 3'd0, sda_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (!slot_end_s) begin
            tick_d = stretch_hold_s ? '0 : (tick_q + TICK_ONE);
          end else if (arb_loss_s) begin
            finish_s   = 1'b1;
            arb_lost_s = 1'b1;
            state_d    = ST_IDLE;
            slot_d     = 3'd0;
            tick_d     = '0;
            scl_d      = 1'b1;
            sda_d      = 1'b1;
          end else if (slot_q == 3'd7) begin
            // Completion without a follow-on request: drives stay at the
            // slot 7 levels (SCL high) until the next bit begins.
            finish_s = 1'b1;
            state_d  = ST_IDLE;
            slot_d   = 3'd0;
            tick_d   = '0;
          end else begin
            slot_d         = slot_q + 3'd1;
            tick_d         = '0;
            {scl_d, sda_d} = slot_drive(cmd_q, slot_q + 3'd1, sda_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  // State, counters and registered bus drives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_IDLE;
      div_q    <= '0;
      slot_q   <= 3'd0;
      tick_q   <= '0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
      rx_bit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      div_q    <= div_d;
      slot_q   <= slot_d;
      tick_q   <= tick_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
      rx_bit_q <= rx_bit_d;
    end
  end

  assign bus.scl      = scl_q;
  assign bus.sda      = sda_q;
  assign bus.busy     = busy_q;
  assign bus.rx_bit   = rx_bit_q;
  // finish and arb_lost must be visible in the very cycle the loss or final
  // tick is observed, so they are decoded from the registered sequencer state.
  assign bus.finish   = finish_s;
  assign bus.arb_lost = arb_lost_s;

endmodule

// File: tb/tb_i2c_master_bit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2c_master_bit_ctrl
//
// Self-checking bench for i2c_master_bit_ctrl (default build). The expected
// waveform of every bit is computed from per-command slot pattern strings and
// the cycle offset since the accept edge; the bus SDA is modelled as a
// wired-AND of the DUT drive and a bench-controlled external pull.
// ----------------------------------------------------------------------------
module tb_i2c_master_bit_ctrl;

  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset_n;
  logic ext_sda;
  logic ext_scl;

  int checks = 0;
  int errors = 0;

  // Reference-model state: last driven levels and last read bit.
  bit m_scl;
  bit m_sda;
  bit m_rx;

  i2c_master_bit_ctrl_if #(.DIV_WIDTH(DW)) bus ();

  assign bus.sda_in = bus.sda & ext_sda;
  assign bus.scl_in = bus.scl & ext_scl;

  i2c_master_bit_ctrl #(.DIV_WIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected SCL/SDA for a command in a slot, read from pattern strings
  // ('h' = SDA keeps its previous level).
  function automatic void model_drive(input logic [2:0] c, input int slot, input bit hold,
                                      output bit s_scl, output bit s_sda);
    string sp;
    string dp;
    byte   cs;
    byte   cd;
    case (c)
      3'b010:         begin sp = "11111111"; dp = "11111100"; end
      3'b011:         begin sp = "00001111"; dp = "h0000011"; end
      3'b100, 3'b110: begin sp = "00001111"; dp = "h0000000"; end
      default:        begin sp = "00001111"; dp = "h1111111"; end
    endcase
    cs = sp[slot];
    cd = dp[slot];
    s_scl = (cs == "1");
    s_sda = (cd == "h") ? hold : (cd == "1");
  endfunction

  // One bit: caller has go/command/clk_div set up; the next rising edge is
  // the accept edge. External SDA is pulled low for cycle offsets k0..k1.
  task automatic do_bit(input logic [2:0] c, input int d, input int k0, input int k1,
                        input bit chain, input logic [2:0] nc, input int nd,
                        output bit lost);
    int n;
    int slot;
    bit fin_tick;
    bit last;
    bit loss;
    bit e_scl;
    bit e_sda;
    bit sda_seen;
    n    = 8 * (d + 1);
    lost = 1'b0;
    @(posedge clock); #1;
    bus.go      = 1'b0;
    bus.clk_div = DW'($urandom);
    for (int k = 1; k <= n; k++) begin
      ext_sda  = (k >= k0 && k <= k1) ? 1'b0 : 1'b1;
      slot     = (k - 1) / (d + 1);
      fin_tick = (k % (d + 1)) == 0;
      model_drive(c, slot, m_sda, e_scl, e_sda);
      sda_seen = e_sda & ext_sda;
      loss     = (c != 3'b001) && fin_tick && (slot == 5 || slot == 7) && e_sda && !ext_sda;
      last     = (k == n) || loss;
      if (last && chain) begin
        bus.go      = 1'b1;
        bus.command = nc;
        bus.clk_div = DW'(nd);
      end
      @(negedge clock);
      chk($sformatf("scl c=%0d k=%0d", c, k), bus.scl, e_scl);
      chk($sformatf("sda c=%0d k=%0d", c, k), bus.sda, e_sda);
      chk($sformatf("busy c=%0d k=%0d", c, k), bus.busy, 1'b1);
      chk($sformatf("finish c=%0d k=%0d", c, k), bus.finish, last);
      chk($sformatf("arb_lost c=%0d k=%0d", c, k), bus.arb_lost, loss);
      chk($sformatf("rx_bit c=%0d k=%0d", c, k), bus.rx_bit, m_rx);
      if (c == 3'b001 && slot == 5 && fin_tick) m_rx = sda_seen;
      if (last) begin
        lost  = loss;
        m_scl = loss ? 1'b1 : e_scl;
        m_sda = loss ? 1'b1 : e_sda;
        break;
      end
      @(posedge clock); #1;
    end
    if (!chain || lost) begin
      @(posedge clock); #1;
      bus.go      = 1'b0;
      bus.command = 3'b000;
      ext_sda     = 1'b1;
      @(negedge clock);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_finish", bus.finish, 1'b0);
      chk("idle_arb", bus.arb_lost, 1'b0);
      chk("idle_scl", bus.scl, m_scl);
      chk("idle_sda", bus.sda, m_sda);
      chk("idle_rx", bus.rx_bit, m_rx);
    end
  endtask

  initial begin
    bit       lost;
    logic [2:0] cur_c;
    logic [2:0] nc;
    int       cur_d;
    int       nd;
    int       n;
    int       k0;
    int       k1;
    bit       chain;

    reset_n     = 1'b0;
    bus.go      = 1'b0;
    bus.command = 3'b000;
    bus.clk_div = '0;
    ext_sda     = 1'b1;
    ext_scl     = 1'b1;
    m_scl       = 1'b1;
    m_sda       = 1'b1;
    m_rx        = 1'b0;

    // Reset values.
    repeat (2) @(negedge clock);
    chk("rst_scl", bus.scl, 1'b1);
    chk("rst_sda", bus.sda, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_finish", bus.finish, 1'b0);
    chk("rst_rx", bus.rx_bit, 1'b0);
    chk("rst_arb", bus.arb_lost, 1'b0);
    reset_n = 1'b1;

    // command 000 with go is ignored.
    @(negedge clock);
    bus.go      = 1'b1;
    bus.command = 3'b000;
    @(posedge clock); #1;
    bus.go = 1'b0;
    @(negedge clock);
    chk("cmd0_busy", bus.busy, 1'b0);
    chk("cmd0_scl", bus.scl, 1'b1);
    chk("cmd0_sda", bus.sda, 1'b1);

    // DATA_0, clk_div=3.
    bus.go = 1'b1; bus.command = 3'b100; bus.clk_div = DW'(3);
    do_bit(3'b100, 3, 0, 0, 1'b0, 3'b000, 0, lost);

    // START then DATA_1 back-to-back, clk_div=0.
    bus.go = 1'b1; bus.command = 3'b010; bus.clk_div = DW'(0);
    do_bit(3'b010, 0, 0, 0, 1'b1, 3'b101, 0, lost);
    do_bit(3'b101, 0, 0, 0, 1'b0, 3'b000, 0, lost);

    // READ_BIT, clk_div=1, slave pulls SDA low during slot 5 only.
    bus.go = 1'b1; bus.command = 3'b001; bus.clk_div = DW'(1);
    do_bit(3'b001, 1, 11, 12, 1'b0, 3'b000, 0, lost);
    chk("read_rx", bus.rx_bit, 1'b0);

    // DATA_1, clk_div=2, SDA forced low from slot 4: loss at slot 5, the go
    // raised in the loss cycle must not start a bit.
    bus.go = 1'b1; bus.command = 3'b101; bus.clk_div = DW'(2);
    do_bit(3'b101, 2, 13, 1000, 1'b1, 3'b100, 2, lost);

    // Reset in slot 3 of STOP.
    bus.go = 1'b1; bus.command = 3'b011; bus.clk_div = DW'(1);
    @(posedge clock); #1;
    bus.go = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("stop_s3_scl", bus.scl, 1'b0);
    chk("stop_s3_sda", bus.sda, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstmid_scl", bus.scl, 1'b1);
    chk("rstmid_sda", bus.sda, 1'b1);
    chk("rstmid_busy", bus.busy, 1'b0);
    chk("rstmid_finish", bus.finish, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_scl = 1'b1; m_sda = 1'b1; m_rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("post_rst_finish", bus.finish, 1'b0);
      chk("post_rst_busy", bus.busy, 1'b0);
    end

    // Randomized bits, optional back-to-back chaining and random SDA pulls.
    cur_c = 3'($urandom_range(1, 7));
    cur_d = $urandom_range(0, 3);
    bus.go = 1'b1; bus.command = cur_c; bus.clk_div = DW'(cur_d);
    for (int i = 0; i < 80; i++) begin
      nc    = 3'($urandom_range(1, 7));
      nd    = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3);
      chain = (i < 79) ? 1'($urandom_range(0, 1)) : 1'b0;
      n     = 8 * (cur_d + 1);
      if ($urandom_range(0, 3) == 0) begin
        k0 = 0; k1 = 0;
      end else begin
        k0 = $urandom_range(1, n);
        k1 = k0 + $urandom_range(0, n);
      end
      do_bit(cur_c, cur_d, k0, k1, chain, nc, nd, lost);
      if (!chain || lost) begin
        bus.go = 1'b1; bus.command = nc; bus.clk_div = DW'(nd);
      end
      cur_c = nc;
      cur_d = nd;
    end
    bus.go = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
